// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder with a combinational result and an enabled output register stage.
// Optional signed-overflow outputs are added when CARRY_SELECT_ADDER_16BIT_OVF_EN is defined.
module carry_select_adder_16bit #(
   parameter int unsigned BLOCK_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   input  logic        en,
`ifdef CARRY_SELECT_ADDER_16BIT_OVF_EN
   output logic        ovf,
   output logic        ovf_q,
`endif
   output logic [15:0] sum,
   output logic        cout,
   output logic [15:0] sum_q,
   output logic        cout_q
);

   localparam int unsigned NBLK = 16 / BLOCK_W;

   // bc[k] is the carry into block k; bc[NBLK] is the final carry-out
   logic [NBLK:0] bc;

   assign bc[0] = cin;

   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      localparam int unsigned LSB = k * BLOCK_W;

      logic [BLOCK_W-1:0] pa;
      logic [BLOCK_W-1:0] pb;

      assign pa = a[LSB +: BLOCK_W];
      assign pb = b[LSB +: BLOCK_W];

      if (k == 0) begin : g_ripple
         logic [BLOCK_W:0] c;

         assign c[0] = bc[0];
         for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
            assign sum[LSB+i] = pa[i] ^ pb[i] ^ c[i];
            assign c[i+1]     = (pa[i] & pb[i]) | (c[i] & (pa[i] ^ pb[i]));
         end
         assign bc[1] = c[BLOCK_W];
      end else begin : g_select
         // Both carry-in hypotheses ripple in parallel; the incoming block carry picks one
         logic [BLOCK_W:0]   c0;
         logic [BLOCK_W:0]   c1;
         logic [BLOCK_W-1:0] s0;
         logic [BLOCK_W-1:0] s1;

         assign c0[0] = 1'b0;
         assign c1[0] = 1'b1;
         for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
            assign s0[i]   = pa[i] ^ pb[i] ^ c0[i];
            assign c0[i+1] = (pa[i] & pb[i]) | (c0[i] & (pa[i] ^ pb[i]));
            assign s1[i]   = pa[i] ^ pb[i] ^ c1[i];
            assign c1[i+1] = (pa[i] & pb[i]) | (c1[i] & (pa[i] ^ pb[i]));
         end

         assign sum[LSB +: BLOCK_W] = bc[k] ? s1 : s0;
         assign bc[k+1]             = bc[k] ? c1[BLOCK_W] : c0[BLOCK_W];
      end
   end

   assign cout = bc[NBLK];

`ifdef CARRY_SELECT_ADDER_16BIT_OVF_EN
   // Carry into bit 15 is recovered as a[15]^b[15]^sum[15]
   assign ovf = a[15] ^ b[15] ^ sum[15] ^ cout;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= 16'd0;
         cout_q <= 1'b0;
      end else if (en) begin
         sum_q  <= sum;
         cout_q <= cout;
      end
   end

endmodule

// File: tb/tb_carry_select_adder_16bit.sv
// Bench for carry_select_adder_16bit: one instance per legal BLOCK_W (2, 4, 8), an arithmetic
// reference model, directed literal vectors and random traffic.
module tb_carry_select_adder_16bit;

   logic        clk;
   logic        rst;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        en;

   logic [15:0] s_w   [3];
   logic        c_w   [3];
   logic [15:0] sq_w  [3];
   logic        cq_w  [3];
`ifdef CARRY_SELECT_ADDER_16BIT_OVF_EN
   logic        o_w   [3];
   logic        oq_w  [3];
`endif

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   carry_select_adder_16bit #(.BLOCK_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
`ifdef CARRY_SELECT_ADDER_16BIT_OVF_EN
      .ovf(o_w[0]), .ovf_q(oq_w[0]),
`endif
      .sum(s_w[0]), .cout(c_w[0]), .sum_q(sq_w[0]), .cout_q(cq_w[0])
   );

   carry_select_adder_16bit #(.BLOCK_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
`ifdef CARRY_SELECT_ADDER_16BIT_OVF_EN
      .ovf(o_w[1]), .ovf_q(oq_w[1]),
`endif
      .sum(s_w[1]), .cout(c_w[1]), .sum_q(sq_w[1]), .cout_q(cq_w[1])
   );

   carry_select_adder_16bit #(.BLOCK_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
`ifdef CARRY_SELECT_ADDER_16BIT_OVF_EN
      .ovf(o_w[2]), .ovf_q(oq_w[2]),
`endif
      .sum(s_w[2]), .cout(c_w[2]), .sum_q(sq_w[2]), .cout_q(cq_w[2])
   );

   // Reference model: plain integer arithmetic
   function automatic logic [16:0] model_add(input logic [15:0] x, input logic [15:0] y,
                                             input logic ci);
      return {1'b0, x} + {1'b0, y} + {16'd0, ci};
   endfunction

   function automatic logic model_ovf(input logic [15:0] x, input logic [15:0] y,
                                      input logic ci);
      logic [16:0] r;
      r = model_add(x, y, ci);
      return (x[15] == y[15]) && (r[15] != x[15]);
   endfunction

   logic [16:0] m_q;
   logic        m_ovf_q;
   logic        m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_q     <= 17'd0;
         m_ovf_q <= 1'b0;
         m_valid <= 1'b1;
      end else if (en) begin
         m_q     <= model_add(a, b, cin);
         m_ovf_q <= model_ovf(a, b, cin);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (a=%h b=%h cin=%b t=%0t)", name, got, exp, a, b,
                  cin, $time);
      end
   endtask

   // Compare every instance against the model on every falling edge
   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("comb_w%0d", 2 << i), {15'd0, c_w[i], s_w[i]},
                {15'd0, model_add(a, b, cin)});
            chk($sformatf("reg_w%0d", 2 << i), {15'd0, cq_w[i], sq_w[i]}, {15'd0, m_q});
`ifdef CARRY_SELECT_ADDER_16BIT_OVF_EN
            chk($sformatf("ovf_w%0d", 2 << i), {31'd0, o_w[i]}, {31'd0, model_ovf(a, b, cin)});
            chk($sformatf("ovfq_w%0d", 2 << i), {31'd0, oq_w[i]}, {31'd0, m_ovf_q});
`endif
         end
      end
   end

   task automatic step(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                       input logic ven, input logic vrst);
      @(negedge clk);
      #2;
      a   = va;
      b   = vb;
      cin = vc;
      en  = ven;
      rst = vrst;
      #1;
   endtask

   // Hand-computed literal expectations on all three instances
   task automatic lit_comb(input string name, input logic [15:0] es, input logic ec);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_sum_w%0d", name, 2 << i), {16'd0, s_w[i]}, {16'd0, es});
         chk($sformatf("%s_cout_w%0d", name, 2 << i), {31'd0, c_w[i]}, {31'd0, ec});
      end
   endtask

   task automatic lit_reg(input string name, input logic [15:0] es, input logic ec);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_sumq_w%0d", name, 2 << i), {16'd0, sq_w[i]}, {16'd0, es});
         chk($sformatf("%s_coutq_w%0d", name, 2 << i), {31'd0, cq_w[i]}, {31'd0, ec});
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      a   = 16'd0;
      b   = 16'd0;
      cin = 1'b0;

      step(16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      step(16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
      step(16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
      lit_reg("rst_hold", 16'd0, 1'b0);
      lit_comb("zero_cin", 16'd1, 1'b0);

      step(16'd14, 16'd1, 1'b1, 1'b0, 1'b1);
      lit_comb("blk_cross", 16'd16, 1'b0);
      step(16'd5, 16'd0, 1'b0, 1'b0, 1'b1);
      lit_comb("five", 16'd5, 1'b0);
      step(16'hFFFF, 16'd0, 1'b1, 1'b0, 1'b1);
      lit_comb("wrap", 16'd0, 1'b1);
      step(16'h7FFF, 16'd1, 1'b0, 1'b0, 1'b1);
      lit_comb("sgn_ovf", 16'h8000, 1'b0);
`ifdef CARRY_SELECT_ADDER_16BIT_OVF_EN
      for (int i = 0; i < 3; i++) chk($sformatf("sgn_ovf_flag_w%0d", 2 << i), {31'd0, o_w[i]}, 32'd1);
`endif
      step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      lit_comb("all_ones", 16'hFFFF, 1'b1);

      step(16'd999, 16'd0, 1'b1, 1'b1, 1'b0);
      lit_comb("k999", 16'd1000, 1'b0);
      step(16'd1234, 16'd4321, 1'b0, 1'b0, 1'b0);
      lit_reg("capture", 16'd1000, 1'b0);
      lit_comb("k5555", 16'd5555, 1'b0);
      step(16'd1, 16'd1, 1'b0, 1'b0, 1'b0);
      lit_reg("hold", 16'd1000, 1'b0);
      step(16'd2, 16'd2, 1'b0, 1'b1, 1'b1);
      lit_reg("hold2", 16'd1000, 1'b0);
      step(16'hFFFF, 16'd3, 1'b0, 1'b1, 1'b0);
      lit_reg("rst_prio", 16'd0, 1'b0);
      step(16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
      lit_reg("cap_carry", 16'd2, 1'b1);

      for (int n = 0; n < 10000; n++) begin
         step(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(3) != 0),
              ($urandom_range(63) == 0));
      end
      step(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/carry_select_adder_16bit.md
Name: carry_select_adder_16bit

Overview:
- 16-bit carry-select adder computing sum = a + b + cin with carry-out.
- Result is combinational, zero-latency, and also captured into an output register stage.
- Used as a fast adder primitive in arithmetic datapaths.
- The registered copy serves pipelined consumers.

Parameters:
- BLOCK_W, 4, width of each carry-select block. Legal values are 2, 4 and 8, each of which divides 16. Block 0 is a plain ripple block fed by cin.

Ports:
- clk  input  1  clock for the output register stage
- rst  input  1  synchronous, active-high reset
- a  input  16  addend A, unsigned
- b  input  16  addend B, unsigned
- cin  input  1  carry-in
- en  input  1  capture enable for the output registers
- sum  output  16  combinational sum bits [15:0] of a+b+cin
- cout  output  1  combinational carry-out (bit 16 of a+b+cin)
- sum_q  output  16  registered sum
- cout_q  output  1  registered carry-out

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Combinational path:
  - {cout,sum} = a + b + cin, exact 17-bit result.
  - No clock dependency: outputs settle within the same delta/time step as any input change.
- Structure:
  - 16/BLOCK_W blocks.
  - Block 0: ripple-carry adder driven by cin.
  - Each block k>0 computes two ripple results in parallel, one assuming carry-in 0 and one assuming carry-in 1.
  - The carry-out of block k-1 selects that block's sum bits and carry through a 2:1 mux.
  - The carry-out of the last block is cout.
  - A behavioural "+" is not acceptable for the core; the result must be bit-exact with a+b+cin for all inputs.
- Wrap-around: 16'hFFFF + 0 + 1 gives sum=0, cout=1. 16'hFFFF + 16'hFFFF + 1 gives sum=16'hFFFF, cout=1.
- No X propagation beyond the affected bits; no latches.
- Register stage, on rising clk:
  - rst=1: sum_q <= 0, cout_q <= 0. Reset has priority over en.
  - rst=0, en=1: sum_q <= sum, cout_q <= cout (and ovf_q <= ovf when OVF_EN is defined).
  - rst=0, en=0: registers hold.
  - Latency from inputs to sum_q/cout_q is 1 cycle.
- Reset mid-operation: the combinational outputs are unaffected. Registered outputs clear on the next edge and stay 0 while rst is high.
- Output reset values: sum_q=0, cout_q=0 (ovf_q=0 when OVF_EN is defined). sum and cout have no reset; they always reflect a, b and cin.

Optional Feature:
- Macro: CARRY_SELECT_ADDER_16BIT_OVF_EN.
- When defined, adds two outputs:
  - ovf (1 bit, combinational): two's-complement signed overflow, equal to the carry into bit 15 XOR the carry out of bit 15.
  - ovf_q (1 bit): registered ovf, same reset, enable and latency as sum_q.
- When undefined, neither port exists and there is no overflow logic.

Test Plan:
- a=0, b=0, cin=1 -> sum=1, cout=0 (combinational, checked after 1 time unit settle).
- a=14, b=1, cin=1 -> sum=16, cout=0 (carry crosses the first 4-bit block boundary).
- a=5, b=0, cin=0 -> sum=5, cout=0. Then a=999, b=0, cin=1 -> sum=1000, cout=0.
- a=16'hFFFF, b=0, cin=1 -> sum=0, cout=1. a=16'h7FFF, b=1, cin=0 -> sum=16'h8000, cout=0, ovf=1 when OVF_EN is defined.
- Register stage:
  - Hold rst=1 for 2 cycles: sum_q=0, cout_q=0.
  - Release rst, drive a=999, b=0, cin=1, en=1: one edge later sum_q=1000.
  - Set en=0 and change the inputs: sum_q stays 1000.
  - Assert rst with en=1: sum_q=0 after the next edge.
- Random: 10,000 vectors over all BLOCK_W values (2, 4, 8). {cout,sum} matches a+b+cin every time; sum_q/cout_q match the previous cycle's values whenever en=1.
